// File: rtl/vga_pkg.sv
// vga_pkg: shared 1024x768@60 timing constants
// and lock-state type for the video timing blocks.
package vga_pkg;

    localparam int HOR_PIXELS  = 1024;
    localparam int VER_PIXELS  = 768;
    localparam int HOR_TOTAL   = 1344;
    localparam int VER_TOTAL   = 806;
    localparam int HBLANK_STOP = HOR_TOTAL;
    localparam int VBLANK_STOP = VER_TOTAL;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        H_ACQ  = 2'd1,
        V_ACQ  = 2'd2,
        LOCKED = 2'd3
    } vga_lock_state_t;

endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: sync polarity normalise, assertion edge
// and saturating period measurement between edges.
// Ports: clk, rst_n, sync_in (raw), cnt_en (period tick),
//        rise (comb edge pulse), period (last edge-to-edge count).
module vga_sync_edge #(
    parameter logic POL = 1'b1,
    parameter int   W   = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sync_in,
    input  logic         cnt_en,
    output logic         rise,
    output logic [W-1:0] period
);

    logic         act;
    logic         act_d;
    logic [W-1:0] cnt;

    assign act  = sync_in ^ ~POL;
    assign rise = act & ~act_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_d  <= 1'b0;
            cnt    <= '0;
            period <= '0;
        end else begin
            act_d <= act;
            if (rise) begin
                period <= cnt;
                cnt    <= {{(W-1){1'b0}}, 1'b1};
            end else if (cnt_en && cnt != {W{1'b1}}) begin
                cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/vga_timing_decoder.sv
// vga_timing_decoder: rebuilds hcount/vcount/blanking from raw
// hsync/vsync, measures line/frame length and tracks lock.
// Ports: clk, rst_n, hsync_in, vsync_in -> hcount, vcount,
//        hblnk, vblnk, locked, timing_err, meas_htotal, meas_vtotal.
module vga_timing_decoder
    import vga_pkg::*;
#(
    parameter int   HTOTAL      = HOR_TOTAL,
    parameter int   VTOTAL      = VER_TOTAL,
    parameter int   HSYNC_START = 1048,
    parameter int   VSYNC_START = 771,
    parameter int   LOCK_FRAMES = 2,
    parameter logic SYNC_POL    = 1'b1,
    parameter int   HPIXELS     = HOR_PIXELS,
    parameter int   VPIXELS     = VER_PIXELS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hblnk,
    output logic        vblnk,
    output logic        locked,
    output logic        timing_err,
    output logic [10:0] meas_htotal,
    output logic [10:0] meas_vtotal
);

    localparam logic [10:0] HT_M1  = 11'(HTOTAL - 1);
    localparam logic [10:0] VT_M1  = 11'(VTOTAL - 1);
    localparam logic [10:0] HS_ST  = 11'(HSYNC_START);
    localparam logic [10:0] VS_ST  = 11'(VSYNC_START);
    localparam logic [10:0] HPIX   = 11'(HPIXELS);
    localparam logic [10:0] VPIX   = 11'(VPIXELS);
    localparam logic [2:0]  LF     = 3'(LOCK_FRAMES);
    localparam logic [11:0] TMO_M1 = 12'(2 * HTOTAL - 1);

    vga_lock_state_t state, state_nxt;

    logic        hs_e, vs_e;
    logic        h_wrap;
    logic [10:0] h_nxt, v_nxt;
    logic [10:0] h_new, v_new;
    logic        h_exp, v_exp;
    logic        h_mis, v_mis;
    logic        tmo;
    logic        err_nxt;
    logic [2:0]  fcnt, fcnt_nxt;
    logic        bad, bad_nxt;
    logic [11:0] tcnt;

    vga_sync_edge #(
        .POL (SYNC_POL),
        .W   (11)
    ) u_h_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .sync_in (hsync_in),
        .cnt_en  (1'b1),
        .rise    (hs_e),
        .period  (meas_htotal)
    );

    // Frame length is counted in lines, so tick on hcount wrap.
    vga_sync_edge #(
        .POL (SYNC_POL),
        .W   (11)
    ) u_v_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .sync_in (vsync_in),
        .cnt_en  (h_wrap),
        .rise    (vs_e),
        .period  (meas_vtotal)
    );

    always_comb begin
        h_wrap = (hcount == HT_M1);
        h_nxt  = h_wrap ? 11'd0 : hcount + 11'd1;
        v_nxt  = vcount;
        if (h_wrap) begin
            v_nxt = (vcount == VT_M1) ? 11'd0 : vcount + 11'd1;
        end
        h_exp = (h_nxt == HS_ST);
        v_exp = (v_nxt == VS_ST) && (h_nxt == 11'd0);
        h_mis = hs_e & ~h_exp;
        v_mis = vs_e & ~v_exp;
        // tcnt saturates, so gate on state to keep SEARCH quiet.
        tmo   = ~hs_e && (tcnt == TMO_M1) && (state != SEARCH);
        h_new = hs_e ? HS_ST : h_nxt;
        v_new = vs_e ? VS_ST : v_nxt;
    end

    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        bad_nxt   = bad;
        err_nxt   = 1'b0;
        unique case (state)
            SEARCH: begin
                if (hs_e) state_nxt = H_ACQ;
            end
            H_ACQ: begin
                if (tmo) state_nxt = SEARCH;
                else if (hs_e && h_exp) state_nxt = V_ACQ;
            end
            V_ACQ: begin
                if (tmo) begin
                    state_nxt = SEARCH;
                end else if (vs_e) begin
                    // A frame only counts if no hs edge slipped in it.
                    bad_nxt = 1'b0;
                    if (v_exp && !bad && !h_mis) begin
                        fcnt_nxt = fcnt + 3'd1;
                        if (fcnt_nxt == LF) state_nxt = LOCKED;
                    end else begin
                        fcnt_nxt = 3'd0;
                    end
                end else if (h_mis) begin
                    fcnt_nxt = 3'd0;
                    bad_nxt  = 1'b1;
                end
            end
            LOCKED: begin
                if (h_mis || v_mis || tmo) begin
                    state_nxt = SEARCH;
                    err_nxt   = 1'b1;
                end
            end
            default: state_nxt = SEARCH;
        endcase
        if (state_nxt != V_ACQ) begin
            fcnt_nxt = 3'd0;
            bad_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SEARCH;
            hcount     <= 11'd0;
            vcount     <= 11'd0;
            hblnk      <= 1'b1;
            vblnk      <= 1'b1;
            locked     <= 1'b0;
            timing_err <= 1'b0;
            fcnt       <= 3'd0;
            bad        <= 1'b0;
            tcnt       <= 12'd0;
        end else begin
            state      <= state_nxt;
            hcount     <= h_new;
            vcount     <= v_new;
            fcnt       <= fcnt_nxt;
            bad        <= bad_nxt;
            locked     <= (state_nxt == LOCKED);
            hblnk      <= (state_nxt != LOCKED) || (h_new >= HPIX);
            vblnk      <= (state_nxt != LOCKED) || (v_new >= VPIX);
            timing_err <= err_nxt;
            if (hs_e) tcnt <= 12'd0;
            else if (tcnt != TMO_M1) tcnt <= tcnt + 12'd1;
        end
    end

endmodule

// File: doc/vga_timing_decoder.md
Name: vga_timing_decoder

Overview:
- Receive-side counterpart of the 1024x768@60 timing generator. Runs at 65 MHz.
- Watches raw hsync/vsync and rebuilds hcount/vcount, hblnk and vblnk.
- Measures line and frame length and declares lock. Flags any sync edge that does not match the vga_pkg timing.
- Sits behind an external video input, or on a loopback of the local timing block, in front of the capture/overlay logic.

Parameters:
- HTOTAL, 1344, clocks per line (vga_pkg HOR_TOTAL).
- VTOTAL, 806, lines per frame (vga_pkg VER_TOTAL).
- HSYNC_START, 1048, hcount value at hsync assertion.
- VSYNC_START, 771, vcount value at vsync assertion.
- LOCK_FRAMES, 2, consecutive good frames needed to reach LOCKED (1..7).
- SYNC_POL, 1, 1 = syncs active-high, 0 = active-low.

Ports:
- clk  in  1  65 MHz pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- hsync_in  in  1  raw horizontal sync, already synchronous to clk.
- vsync_in  in  1  raw vertical sync, already synchronous to clk.
- hcount  out  11  reconstructed horizontal position.
- vcount  out  11  reconstructed vertical position.
- hblnk  out  1  hcount >= HOR_PIXELS, or not LOCKED.
- vblnk  out  1  vcount >= VER_PIXELS, or not LOCKED.
- locked  out  1  FSM is in LOCKED.
- timing_err  out  1  one-cycle pulse on a sync mismatch.
- meas_htotal  out  11  clocks between the last two hsync assertions.
- meas_vtotal  out  11  lines between the last two vsync assertions.

Behaviour:
- Reset and interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low. Every output is registered.
- Reset values: hcount=0, vcount=0, hblnk=1, vblnk=1, locked=0, timing_err=0, meas_htotal=0, meas_vtotal=0, FSM=SEARCH.
- Input handling:
  - Syncs are XORed with ~SYNC_POL to get active-high hs/vs, then registered once (hs_d, vs_d).
  - Assertion edge is detected as hs & ~hs_d (likewise for vs).
- Latency: outputs lag the sync inputs by exactly 1 clock. In the cycle after the first high sample of hsync, hcount = HSYNC_START.
- Free-running counters:
  - hcount counts 0..HTOTAL-1 and wraps to 0.
  - vcount increments on each hcount wrap and wraps from VTOTAL-1 to 0.
- Horizontal edge check:
  - An hs edge is "expected" when the free-running next hcount equals HSYNC_START.
  - Every hs edge reloads hcount to HSYNC_START regardless.
- Vertical edge check:
  - A vs edge is "expected" when next vcount == VSYNC_START and next hcount == 0.
  - Every vs edge reloads vcount to VSYNC_START. hcount is left untouched.
- Period measurement:
  - The period counter restarts at 1 on each edge.
  - It saturates at 2047 and is latched into meas_* on the next edge.
  - meas_vtotal counts hcount wraps, not clocks.
- FSM states, SEARCH -> H_ACQ -> V_ACQ -> LOCKED:
  - SEARCH: wait for hs edge, reload, go to H_ACQ.
  - H_ACQ: an expected hs edge goes to V_ACQ. An unexpected hs edge stays in H_ACQ (re-seeds, no err pulse).
  - V_ACQ: a vs edge reloads. Frame counter increments on each expected vs edge with no hs mismatch during the frame. The counter reaching LOCK_FRAMES goes to LOCKED. Any mismatch clears the counter and stays in V_ACQ.
  - LOCKED: an unexpected hs or vs edge pulses timing_err for 1 cycle and goes to SEARCH; the reload still happens.
- Timeout: in any state other than SEARCH, no hs edge for 2*HTOTAL clocks goes to SEARCH. If this happens in LOCKED, timing_err also pulses.
- Blanking: hblnk/vblnk are forced to 1 whenever the next state is not LOCKED.
- Simultaneous hs and vs edges: both reloads apply; the checks are evaluated independently; a single err pulse is produced.
- rst_n asserted mid-frame: immediate return to reset values. No output glitch beyond the asynchronous clear.

Decomposition:
- vga_pkg additions:
  - HOR_TOTAL=1344 (=HBLANK_STOP) and VER_TOTAL=806 (=VBLANK_STOP), which become the parameter defaults.
  - Typedef vga_lock_state_t (enum logic [1:0]: SEARCH, H_ACQ, V_ACQ, LOCKED).
  - Existing HOR_PIXELS/VER_PIXELS are used for blanking.
- One sub-module, vga_sync_edge: polarity normalise, delay register, edge pulse, and the saturating period counter. It is instantiated twice, once for h (clock-counted) and once for v (wrap-counted).

Test Plan:
- Timing generator loopback from reset:
  - First hs high sample -> next cycle hcount=1048, state H_ACQ.
  - After the first vs edge -> vcount=771.
  - locked=1 after 2 complete good frames; meas_htotal=1344, meas_vtotal=806.
  - Thereafter hcount/vcount equal the generator's, delayed by 1 cycle, and hblnk/vblnk match.
- SYNC_POL=0 with inverted syncs -> identical lock timing and counter values.
- While LOCKED, shorten one line to 1343 clocks:
  - timing_err pulses 1 cycle; locked=0; hcount reloads to 1048; meas_htotal=1343.
  - Relock after 2 further good frames.
- While LOCKED, hold hsync inactive:
  - After 2688 clocks, timing_err pulses, state SEARCH, locked=0, hblnk=vblnk=1.
- vsync edge at hcount=5 during V_ACQ:
  - Frame counter clears, vcount=771, no err pulse, locked stays 0.
- Assert rst_n low mid-line at hcount=500:
  - All outputs return to reset values within the same cycle.
  - After release, reacquisition restarts from SEARCH.
